// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port data memory
// between two LSU lanes. Optional perf counters: MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  lane_e prio_q;
  lane_e prio_d;
  logic  g0;
  logic  g1;

  // Zero or negative widths make no sense for any bus.
  if (ADDR_W < 1 || DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("mem_port_arbiter: widths must be positive");
  end

  // Grant: a lone requester wins, a tie goes to the pointer lane.
  // Held in reset so nothing reaches memory while rst is low.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst) begin
      unique case (1'b1)
        (req0 && req1): begin
          g0 = (prio_q == LANE0);
          g1 = (prio_q == LANE1);
        end
        (req0 && !req1): g0 = 1'b1;
        (!req0 && req1): g1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign gnt0 = g0;
  assign gnt1 = g1;

  // Steer the granted lane onto the memory port; idle drives zeros.
  always_comb begin
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    unique case (1'b1)
      g0: begin
        mem_read_en    = !we0;
        mem_write_en   = we0;
        mem_address    = addr0;
        mem_write_data = wdata0;
      end
      g1: begin
        mem_read_en    = !we1;
        mem_write_en   = we1;
        mem_address    = addr1;
        mem_write_data = wdata1;
      end
      default: ;
    endcase
  end

  // Next pointer: the lane that just lost gets the next tie.
  always_comb begin
    prio_d = prio_q;
    if (g0) begin
      prio_d = LANE1;
    end else if (g1) begin
      prio_d = LANE0;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= LANE0;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Lane 0 read response: one-cycle valid, data held until next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rdata0  <= '0;
    end else begin
      rvalid0 <= g0 && !we0;
      if (g0 && !we0) begin
        rdata0 <= mem_read_data;
      end
    end
  end

  // Lane 1 read response: one-cycle valid, data held until next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid1 <= 1'b0;
      rdata1  <= '0;
    end else begin
      rvalid1 <= g1 && !we1;
      if (g1 && !we1) begin
        rdata1 <= mem_read_data;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Saturating per-lane grant counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (g0 && gnt_cnt0 != CntMax) begin
        gnt_cnt0 <= gnt_cnt0 + 1'b1;
      end
      if (g1 && gnt_cnt1 != CntMax) begin
        gnt_cnt1 <= gnt_cnt1 + 1'b1;
      end
    end
  end

  // Saturating count of cycles where both lanes compete.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (req0 && req1 && conflict_cnt != CntMax) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random two-lane traffic checked against a
// behavioural model of round-robin arbitration and memory contents.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0;
  logic          req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_read_en, mem_write_en;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_read_data;
`ifdef MEM_ARB_PERF_EN
  logic [CW-1:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] env_mem [64] = '{default: '0};
  logic [DW-1:0] ref_mem [64] = '{default: '0};

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
`ifdef MEM_ARB_PERF_EN
    ,
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
    .conflict_cnt(conflict_cnt)
`endif
  );

  // Memory: combinational read, write on the clock edge.
  assign mem_read_data = mem_read_en ? env_mem[mem_address[7:2]] : '0;

  always @(posedge clk)
    if (mem_write_en) env_mem[mem_address[7:2]] <= mem_write_data;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endfunction

  function automatic int sat(int c);
    return (c >= (1 << CW) - 1) ? (1 << CW) - 1 : c + 1;
  endfunction

  // Model state: who won last, pending responses, counts.
  logic        m_last = 1'b1;
  logic        m_rv0 = 1'b0, m_rv1 = 1'b0;
  logic [31:0] m_rd0 = '0, m_rd1 = '0;
  int          m_g0 = 0, m_g1 = 0, m_cf = 0;

  always @(negedge clk) begin : cmp
    logic e0, e1, er, ew;
    logic [31:0] ea, ed;
    if (!rst) begin
      chk("rst_gnt", {30'd0, gnt1, gnt0}, 0);
      chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_mem_en", {30'd0, mem_read_en, mem_write_en}, 0);
      chk("rst_mem_addr", mem_address, 0);
      chk("rst_mem_wdata", mem_write_data, 0);
      m_last = 1'b1;
      m_rv0 = 1'b0; m_rv1 = 1'b0;
      m_rd0 = '0; m_rd1 = '0;
      m_g0 = 0; m_g1 = 0; m_cf = 0;
    end else begin
      e0 = req0 && (!req1 || m_last);
      e1 = req1 && !e0;
      ea = '0; ed = '0; er = 1'b0; ew = 1'b0;
      if (e0) begin
        ea = addr0; ed = wdata0; ew = we0; er = !we0;
      end
      if (e1) begin
        ea = addr1; ed = wdata1; ew = we1; er = !we1;
      end
      chk("gnt0", gnt0, e0);
      chk("gnt1", gnt1, e1);
      chk("mem_read_en", mem_read_en, er);
      chk("mem_write_en", mem_write_en, ew);
      chk("mem_address", mem_address, ea);
      chk("mem_write_data", mem_write_data, ed);
      chk("rvalid0", rvalid0, m_rv0);
      chk("rvalid1", rvalid1, m_rv1);
      chk("rdata0", rdata0, m_rd0);
      chk("rdata1", rdata1, m_rd1);
`ifdef MEM_ARB_PERF_EN
      chk("gnt_cnt0", gnt_cnt0, m_g0);
      chk("gnt_cnt1", gnt_cnt1, m_g1);
      chk("conflict_cnt", conflict_cnt, m_cf);
`endif
      m_rv0 = e0 && !we0;
      m_rv1 = e1 && !we1;
      if (m_rv0) m_rd0 = ref_mem[addr0[7:2]];
      if (m_rv1) m_rd1 = ref_mem[addr1[7:2]];
      if (e0 && we0) ref_mem[addr0[7:2]] = wdata0;
      if (e1 && we1) ref_mem[addr1[7:2]] = wdata1;
      if (e0) m_last = 1'b0;
      else if (e1) m_last = 1'b1;
      if (e0) m_g0 = sat(m_g0);
      if (e1) m_g1 = sat(m_g1);
      if (req0 && req1) m_cf = sat(m_cf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic lane_step(input logic g, inout logic rq, inout logic w,
                           inout logic [31:0] a, inout logic [31:0] d);
    int r;
    logic [31:0] rr;
    r = $urandom_range(0, 99);
    rr = $urandom();
    if (rq && !g) begin
      if (r < 10) rq = 1'b0;
    end else begin
      rq = 1'b0;
      if (r < 60) begin
        rq = 1'b1;
        w = rr[8];
        a = {rr[31:8], 2'b00, rr[3:0], 2'b00};
        d = $urandom();
      end
    end
  endtask

  logic [3:0] g0_pat = 4'b0101;
  logic [3:0] g1_pat = 4'b1010;
  logic [3:0] rv0_pat = 4'b1010;
  logic [3:0] rv1_pat = 4'b0100;

  initial begin
    logic s0, s1;
    int   rcnt;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mid();
    chk("idle_rd_en", mem_read_en, 0);
    chk("idle_wr_en", mem_write_en, 0);
    chk("idle_gnt", {30'd0, gnt1, gnt0}, 0);

    tick();
    req0 = 1'b1; we0 = 1'b1;
    addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    mid();
    chk("t1_wr_gnt0", gnt0, 1);
    chk("t1_wr_en", mem_write_en, 1);
    chk("t1_wr_addr", mem_address, 32'h10);
    tick();
    we0 = 1'b0;
    mid();
    chk("t1_rd_gnt0", gnt0, 1);
    chk("t1_rd_en", mem_read_en, 1);
    chk("t1_rv_early", rvalid0, 0);
    tick();
    req0 = 1'b0;
    mid();
    chk("t1_rvalid0", rvalid0, 1);
    chk("t1_rdata0", rdata0, 32'hDEADBEEF);
    tick();
    mid();
    chk("t1_rv_pulse", rvalid0, 0);

    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("t2_gnt0", gnt0, g0_pat[i]);
      chk("t2_gnt1", gnt1, g1_pat[i]);
      chk("t2_rv0", rvalid0, rv0_pat[i]);
      chk("t2_rv1", rvalid1, rv1_pat[i]);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    mid();
    chk("t2_rv1_last", rvalid1, 1);
    chk("t2_rdata0", rdata0, 32'hDEADBEEF);

    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h12345678;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    mid();
    chk("t3_gnt0", gnt0, 1);
    chk("t3_gnt1_wait", gnt1, 0);
    tick();
    req0 = 1'b0;
    mid();
    chk("t3_gnt1", gnt1, 1);
    tick();
    req1 = 1'b0;
    mid();
    chk("t3_rvalid1", rvalid1, 1);
    chk("t3_rdata1", rdata1, 32'h12345678);

    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    mid();
    chk("t4_gnt0", gnt0, 1);
    tick();
    rst = 1'b0;
    mid();
    chk("t4_rv0_rst", rvalid0, 0);
    chk("t4_gnt0_rst", gnt0, 0);
    tick();
    rst = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
    mid();
    chk("t4_win0", gnt0, 1);
    chk("t4_lose1", gnt1, 0);
    tick();
    req0 = 1'b0; req1 = 1'b0;

`ifdef MEM_ARB_PERF_EN
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
    repeat (6) tick();
    req0 = 1'b0; req1 = 1'b0;
    mid();
    chk("p_gnt_cnt0", gnt_cnt0, 3);
    chk("p_gnt_cnt1", gnt_cnt1, 3);
    chk("p_conflict", conflict_cnt, 6);
`endif

    rcnt = 0;
    for (int c = 0; c < 4000; c++) begin
      mid();
      s0 = gnt0;
      s1 = gnt1;
      tick();
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) rst = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        rcnt = 2;
        req0 = 1'b0;
        req1 = 1'b0;
      end else begin
        lane_step(s0, req0, we0, addr0, wdata0);
        lane_step(s1, req1, we1, addr1, wdata1);
      end
    end
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
